// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and full/empty flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  push,
  input  logic                  pull,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [WORD_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push_acc, pull_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still legal when the head is read in the same cycle.
  assign pull_acc = pull & ~empty;
  assign push_acc = push & (~full | pull_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pull_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_acc, pull_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (res && push_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (!res) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (push & ~push_acc);
      underflow_q <= underflow_q | (pull & ~pull_acc);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a queue scoreboard predicts dout, count and flags.
module tb_sync_fifo;

  localparam int Depth = 8;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       push = 1'b0;
  logic       pull = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       empty, full;
  logic [3:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
  logic       exp_ovf, exp_unf;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  sync_fifo #(
    .WORD_WIDTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk      (clk),
    .res      (res),
    .push     (push),
    .pull     (pull),
    .din      (din),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .count    (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(sb.size()));
    check("empty", 32'(empty), 32'(sb.size() == 0));
    check("full", 32'(full), 32'(sb.size() == Depth));
    if (sb.size() > 0) check("dout_head", 32'(dout), 32'(sb[0]));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
`endif
  endtask

  // Drive one cycle of push/pull; the popped word is compared before the edge.
  task automatic step(input logic p, input logic q, input logic [7:0] d);
    bit pull_ok, push_ok;
    logic [7:0] exp_word;
    push = p;
    pull = q;
    din  = d;
    #1;
    pull_ok = q && (sb.size() > 0);
    push_ok = p && ((sb.size() < Depth) || pull_ok);
    if (pull_ok) begin
      exp_word = sb.pop_front();
      check("dout_pull", 32'(dout), 32'(exp_word));
    end
    if (push_ok) sb.push_back(d);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    if (p && !push_ok) exp_ovf = 1'b1;
    if (q && !pull_ok) exp_unf = 1'b1;
`endif
    @(posedge clk);
    #1;
    push = 1'b0;
    pull = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input logic p);
    push = p;
    din  = 8'h99;
    res  = 1'b0;
    @(posedge clk);
    #1;
    res  = 1'b1;
    push = 1'b0;
    sb.delete();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
`endif
    check_state();
  endtask

  initial begin
    do_reset(1'b0);

    // Single word through
    step(1'b1, 1'b0, 8'hAA);
    step(1'b0, 1'b1, 8'h00);

    // Fill with 0..7, overflow attempt, drain
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'hEE);
    for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 8'h00);

    // All-ones pattern
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 8'h00);

    // Streaming with occupancy held at one
    step(1'b1, 1'b0, 8'h07);
    for (int i = 6; i >= 0; i--) step(1'b1, 1'b1, 8'(i));
    step(1'b0, 1'b1, 8'h00);

    // Pull on empty, then push+pull on empty
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h00);

    // Push+pull while full: write lands in the freed slot
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b1, 1'b1, 8'h77);
    step(1'b1, 1'b0, 8'h55);
    for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 8'h00);

    // Reset mid-operation with push asserted discards everything
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b0, 8'h03);
    do_reset(1'b1);
    step(1'b1, 1'b0, 8'hC3);
    step(1'b0, 1'b1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
